matmul_param_engine: RTL and testbench

//  Parametrised NxN matrix-multiply engine computing C = A x B, or C = A x B^T in transpose mode.

---
 rtl/matmul_param_engine.sv | 179 +++++++++++++++++
 tb/tb_matmul_param_engine.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_param_engine.sv
// matmul_param_engine: streaming NxN matrix multiply, C = A x B or A x B^T.
// Reads A/B from 1-cycle synchronous RAMs, writes C elements to a result RAM.
module matmul_param_engine #(
    parameter int N      = 8,
    parameter int DATA_W = 8,
    parameter int SIGNED = 1,
    parameter int ACC_W  = 19,
    parameter int CNT_W  = 11,
    localparam int LW    = $clog2(N),
    localparam int AW    = 2 * LW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              b_transpose,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  clock_count,
    output logic [AW-1:0]     a_addr,
    input  logic [DATA_W-1:0] a_rdata,
    output logic [AW-1:0]     b_addr,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              c_we,
    output logic [AW-1:0]     c_addr,
    output logic [ACC_W-1:0]  c_wdata
);

    localparam int  PW   = 2 * DATA_W;
    localparam bit  SG   = (SIGNED != 0);
    localparam logic [LW-1:0] KMAX = LW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    logic          bt;
    logic [1:0]    drain;
    logic [LW-1:0] i, j, k;
    logic [LW-1:0] i_nx, j_nx, k_nx;
    logic          last_issue;

    // stage 1: RAM data cycle, stage 2: product register cycle
    logic          s1_v, s1_first, s1_last;
    logic [AW-1:0] s1_c;
    logic          s2_v, s2_first, s2_last;
    logic [AW-1:0] s2_c;

    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_nx;
    logic [PW-1:0]    a_ext, b_ext;
    logic [ACC_W-1:0] prod_acc;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nx;

    // next (i,j,k) in k-innermost order; wraps naturally for power-of-two N
    always_comb begin
        k_nx = k + 1'b1;
        j_nx = j;
        i_nx = i;
        if (k == KMAX) begin
            j_nx = j + 1'b1;
            if (j == KMAX) begin
                i_nx = i + 1'b1;
            end
        end
        last_issue = (i == KMAX) && (j == KMAX) && (k == KMAX);
    end

    // operand extension, multiply and accumulate arithmetic
    always_comb begin
        a_ext    = {{DATA_W{SG & a_rdata[DATA_W-1]}}, a_rdata};
        b_ext    = {{DATA_W{SG & b_rdata[DATA_W-1]}}, b_rdata};
        prod_nx  = a_ext * b_ext;
        prod_acc = {{(ACC_W-PW){SG & prod[PW-1]}}, prod};
        acc_nx   = s2_first ? prod_acc : acc + prod_acc;
    end

    // control FSM, address issue and cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            bt          <= 1'b0;
            drain       <= 2'd0;
            clock_count <= '0;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            a_addr      <= '0;
            b_addr      <= '0;
        end else begin
            if ((state == RUN || state == DRAIN) && clock_count != '1) begin
                clock_count <= clock_count + 1'b1;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        bt          <= b_transpose;
                        clock_count <= '0;
                        i           <= '0;
                        j           <= '0;
                        k           <= '0;
                        a_addr      <= '0;
                        b_addr      <= '0;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        state <= DRAIN;
                        drain <= 2'd0;
                    end else begin
                        i      <= i_nx;
                        j      <= j_nx;
                        k      <= k_nx;
                        a_addr <= {i_nx, k_nx};
                        b_addr <= bt ? {j_nx, k_nx} : {k_nx, j_nx};
                    end
                end
                DRAIN: begin
                    drain <= drain + 2'd1;
                    if (drain == 2'd2) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MAC pipeline with tags; result strobe on the last k of each element
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_c     <= '0;
            s2_v     <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_c     <= '0;
            prod     <= '0;
            acc      <= '0;
            c_we     <= 1'b0;
            c_addr   <= '0;
            c_wdata  <= '0;
        end else begin
            s1_v     <= (state == RUN);
            s1_first <= (k == '0);
            s1_last  <= (k == KMAX);
            s1_c     <= {i, j};
            s2_v     <= s1_v;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_c     <= s1_c;
            prod     <= prod_nx;
            c_we     <= 1'b0;
            if (s2_v) begin
                acc <= acc_nx;
                if (s2_last) begin
                    c_we    <= 1'b1;
                    c_addr  <= s2_c;
                    c_wdata <= acc_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_param_engine.sv
// tb_matmul_param_engine: scoreboard bench for the matrix-multiply engine.
// Expected C elements come from a plain-arithmetic reference model.
module tb_matmul_param_engine;

    localparam int N      = 8;
    localparam int DATA_W = 8;
    localparam int SIGNED = 1;
    localparam int ACC_W  = 19;
    localparam int CNT_W  = 11;
    localparam int LW     = $clog2(N);
    localparam int AW     = 2 * LW;
    localparam int NN     = N * N;
    localparam int FINAL  = N * N * N + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              b_transpose;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  clock_count;
    logic [AW-1:0]     a_addr;
    logic [DATA_W-1:0] a_rdata;
    logic [AW-1:0]     b_addr;
    logic [DATA_W-1:0] b_rdata;
    logic              c_we;
    logic [AW-1:0]     c_addr;
    logic [ACC_W-1:0]  c_wdata;

    matmul_param_engine #(
        .N(N), .DATA_W(DATA_W), .SIGNED(SIGNED),
        .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .b_transpose(b_transpose), .busy(busy), .done(done),
        .clock_count(clock_count),
        .a_addr(a_addr), .a_rdata(a_rdata),
        .b_addr(b_addr), .b_rdata(b_rdata),
        .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata)
    );

    initial forever #5 clk = ~clk;

    logic [DATA_W-1:0] mem_a [NN];
    logic [DATA_W-1:0] mem_b [NN];

    // synchronous-read source RAMs, one cycle latency
    always @(posedge clk) begin
        a_rdata <= mem_a[a_addr];
        b_rdata <= mem_b[b_addr];
    end

    typedef struct {
        logic [AW-1:0]    addr;
        logic [ACC_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   prev_we = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // monitor: pops the scoreboard on every C write strobe
    exp_t me;
    always @(negedge clk) begin
        if (c_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL c_we_unexpected: addr %0d data %0d", c_addr, c_wdata);
            end else begin
                me = sb.pop_front();
                check("c_addr", c_addr, me.addr);
                check("c_wdata", c_wdata, me.data);
            end
            if (prev_we >= 0) check("c_we_spacing", cyc - prev_we, N);
            prev_we = cyc;
            pulses++;
        end
    end

    function automatic int sval(logic [DATA_W-1:0] x);
        int v = int'(x);
        if (SIGNED != 0 && x[DATA_W-1]) v -= (1 << DATA_W);
        return v;
    endfunction

    // reference: C[i][j] = sum_k A[i][k] * B'[k][j]
    function automatic void push_expected(bit bt);
        exp_t e;
        int s;
        logic [DATA_W-1:0] bv;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) begin
                    bv = bt ? mem_b[j*N+k] : mem_b[k*N+j];
                    s += sval(mem_a[i*N+k]) * sval(bv);
                end
                e.addr = AW'(i * N + j);
                e.data = ACC_W'(s);
                sb.push_back(e);
            end
        end
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mem_a[r*N+c] = (r == c) ? DATA_W'(1) : '0;
                mem_b[r*N+c] = DATA_W'(8 * r + c - 32);
            end
    endtask

    task automatic fill_const(logic [DATA_W-1:0] v);
        for (int n = 0; n < NN; n++) begin
            mem_a[n] = v;
            mem_b[n] = v;
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < NN; n++) begin
            mem_a[n] = DATA_W'($urandom);
            mem_b[n] = DATA_W'($urandom);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < FINAL + 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    // called at a negedge; leaves us at the negedge of RUN cycle 0
    task automatic launch(bit bt);
        push_expected(bt);
        pulses = 0;
        prev_we = -1;
        b_transpose = bt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b_transpose = ~bt;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        check("count_cleared", clock_count, 0);
    endtask

    task automatic finish_job();
        int n;
        wait_done(n);
        check("clock_count", clock_count, FINAL);
        check("c_we_pulses", pulses, NN);
        check("sb_empty", sb.size(), 0);
        check("busy_at_done", busy, 0);
        @(negedge clk);
        check("count_held", clock_count, FINAL);
        check("done_held", done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        b_transpose = 1'b0;
        fill_ramp();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_c_we", c_we, 0);
        check("rst_count", clock_count, 0);
        check("rst_a_addr", a_addr, 0);
        check("rst_b_addr", b_addr, 0);
        check("rst_c_addr", c_addr, 0);
        check("rst_c_wdata", c_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // identity A, ramp B, normal and transposed
        launch(1'b0);
        finish_job();
        launch(1'b1);
        finish_job();

        // extreme negative operands
        fill_const(DATA_W'(-128));
        launch(1'b0);
        finish_job();

        // start pulses mid-run must be ignored
        fill_random();
        launch(1'b0);
        repeat (9) @(negedge clk);
        start = 1'b1;
        b_transpose = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (289) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_job();

        // reset mid-job aborts, restart is complete
        fill_ramp();
        launch(1'b0);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_c_we", c_we, 0);
        check("abort_count", clock_count, 0);
        check("abort_done", done, 0);
        sb.delete();
        repeat (10) @(negedge clk);
        launch(1'b0);
        finish_job();

        // random signed jobs, random mode
        for (int t = 0; t < 3; t++) begin
            fill_random();
            launch(1'($urandom));
            finish_job();
        end

        // back-to-back with start held high through DONE
        fill_random();
        push_expected(1'b0);
        pulses = 0;
        prev_we = -1;
        b_transpose = 1'b0;
        start = 1'b1;
        @(negedge clk);
        wait_done(n);
        check("b2b1_count", clock_count, FINAL);
        check("b2b1_pulses", pulses, NN);
        push_expected(1'b0);
        pulses = 0;
        prev_we = -1;
        @(negedge clk);
        start = 1'b0;
        check("b2b2_busy", busy, 1);
        check("b2b2_done_low", done, 0);
        check("b2b2_count0", clock_count, 0);
        wait_done(n);
        check("b2b2_done_cycles", n, FINAL);
        check("b2b2_count", clock_count, FINAL);
        check("b2b2_pulses", pulses, NN);
        check("b2b2_sb_empty", sb.size(), 0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
